// File: rtl/core_clk_rst_ctrl_if.sv
// Board-side control and status bundle of the core clock-enable/reset controller.
// The controller takes the slave view and the board/testbench takes the master view.
interface core_clk_rst_ctrl_if #(
  parameter int DIV_W       = 8,
  parameter int NUM_RST_REQ = 2
);
  logic                   step_n;
  logic                   run_mode;
  logic [DIV_W-1:0]       div_val;
  logic [NUM_RST_REQ-1:0] rst_req;
  logic                   core_rst;
  logic                   core_ce;
  logic                   por_done;
  logic [15:0]            ce_count;

  modport master (
    output step_n, run_mode, div_val, rst_req,
    input  core_rst, core_ce, por_done, ce_count
  );

  modport slave (
    input  step_n, run_mode, div_val, rst_req,
    output core_rst, core_ce, por_done, ce_count
  );
endinterface

// File: rtl/core_clk_rst_ctrl.sv
// Clock-enable and reset controller for the CPU core: power-on timer, stretched reset,
// debounced single-step key, run-mode divider and a committed-cycle counter.
module core_clk_rst_ctrl #(
  parameter int POR_CYCLES      = 33554432,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_STRETCH     = 16,
  parameter int NUM_RST_REQ     = 2,
  parameter int DIV_W           = 8
) (
  input  logic                clk50,
  input  logic                rst,
  core_clk_rst_ctrl_if.slave  bus
);

  localparam int POR_W  = $clog2(POR_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STR_W  = $clog2(RST_STRETCH + 1);
  localparam int SYNC_W = NUM_RST_REQ + 2;

  localparam logic [POR_W-1:0]  POR_LAST   = POR_W'(POR_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [STR_W-1:0]  STR_INIT   = STR_W'(RST_STRETCH);
  // Bit 0 is the step key, which idles released (1); everything else idles low.
  localparam logic [SYNC_W-1:0] SYNC_IDLE  = SYNC_W'(1);

  // Synchroniser layout: [0] step_n, [1] run_mode, [SYNC_W-1:2] rst_req.
  logic [SYNC_W-1:0] sync_meta_q, sync_meta_d;
  logic [SYNC_W-1:0] sync_q, sync_d;

  logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
  logic              por_done_q, por_done_d;
  logic [STR_W-1:0]  stretch_q, stretch_d;
  logic              core_rst_q, core_rst_d;
  logic              deb_q, deb_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              press_q, press_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              tick_q, tick_d;
  logic              core_ce_q, core_ce_d;
  logic [15:0]       ce_count_q, ce_count_d;

  logic              step_s;
  logic              run_s;
  logic              req_any;
  logic              cause;
  logic [DEB_W-1:0]  deb_inc;

  assign step_s  = sync_q[0];
  assign run_s   = sync_q[1];
  assign req_any = |sync_q[SYNC_W-1:2];
  assign cause   = ~por_done_q | req_any;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    sync_meta_d = {bus.rst_req, bus.run_mode, bus.step_n};
    sync_d      = sync_meta_q;
    por_cnt_d   = por_cnt_q;
    por_done_d  = por_done_q;
    stretch_d   = stretch_q;
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    deb_inc     = deb_cnt_q + 1'b1;
    div_cnt_d   = '0;
    tick_d      = 1'b0;

    if (!por_done_q) begin
      por_cnt_d = por_cnt_q + 1'b1;
      if (por_cnt_d == POR_LAST) begin
        por_done_d = 1'b1;
      end
    end

    // Any live cause re-arms the full stretch, so release is never early.
    if (cause) begin
      stretch_d = STR_INIT;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end
    core_rst_d = cause | (stretch_d != '0);

    if (step_s != deb_q) begin
      if (deb_inc == DEB_LAST) begin
        deb_d = step_s;
      end else begin
        deb_cnt_d = deb_inc;
      end
    end
    // Presses seen in reset or run mode are dropped here rather than queued.
    press_d = deb_q & ~deb_d & ~run_s & ~core_rst_q;

    if (run_s && !core_rst_q) begin
      if (div_cnt_q == bus.div_val) begin
        tick_d = 1'b1;
      end else if (div_cnt_q < bus.div_val) begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    // Selecting by the current mode cancels a tick or press from the other mode.
    core_ce_d  = ~core_rst_d & (run_s ? tick_q : press_q);
    ce_count_d = core_rst_d ? '0 : ce_count_q + {15'd0, core_ce_d};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      sync_meta_q <= SYNC_IDLE;
      sync_q      <= SYNC_IDLE;
      por_cnt_q   <= '0;
      por_done_q  <= 1'b0;
      stretch_q   <= '0;
      core_rst_q  <= 1'b1;
      deb_q       <= 1'b1;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      div_cnt_q   <= '0;
      tick_q      <= 1'b0;
      core_ce_q   <= 1'b0;
      ce_count_q  <= '0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      por_cnt_q   <= por_cnt_d;
      por_done_q  <= por_done_d;
      stretch_q   <= stretch_d;
      core_rst_q  <= core_rst_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      div_cnt_q   <= div_cnt_d;
      tick_q      <= tick_d;
      core_ce_q   <= core_ce_d;
      ce_count_q  <= ce_count_d;
    end
  end

  assign bus.core_rst = core_rst_q;
  assign bus.core_ce  = core_ce_q;
  assign bus.por_done = por_done_q;
  assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_core_clk_rst_ctrl.sv
// Directed bench for core_clk_rst_ctrl with short POR/debounce/stretch settings.
// Inputs are driven and outputs sampled on the falling edge of clk50.
module tb_core_clk_rst_ctrl;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;

  int checks   = 0;
  int failures = 0;

  core_clk_rst_ctrl_if #(.DIV_W(8), .NUM_RST_REQ(2)) bus ();

  core_clk_rst_ctrl #(
    .POR_CYCLES      (8),
    .DEBOUNCE_CYCLES (4),
    .RST_STRETCH     (3),
    .NUM_RST_REQ     (2),
    .DIV_W           (8)
  ) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // Returns the number of falling edges until core_ce is seen high, 0 on timeout.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk50);
      if (bus.core_ce && n == 0) n = i;
      if (n != 0) i = limit;
    end
  endtask

  // Counts core_ce pulses over n cycles.
  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk50);
      if (bus.core_ce) pulses++;
    end
  endtask

  task automatic hard_reset();
    @(negedge clk50);
    rst = 1'b1;
    @(negedge clk50);
    rst = 1'b0;
    cycles(20);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int por_rise, rst_fall, rst_rise, ce_seen;
    int first, pulses, wide, prev_ce, n;

    bus.step_n   = 1'b1;
    bus.run_mode = 1'b0;
    bus.div_val  = 8'd0;
    bus.rst_req  = 2'b00;
    cycles(3);

    check("reset_core_rst", 32'(bus.core_rst), 32'd1);
    check("reset_core_ce",  32'(bus.core_ce),  32'd0);
    check("reset_por_done", 32'(bus.por_done), 32'd0);
    check("reset_ce_count", 32'(bus.ce_count), 32'd0);

    // Power-on: por_done at edge 8, core_rst drops 3 edges later, no enables.
    rst = 1'b0;
    por_rise = 0; rst_fall = 0; ce_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk50);
      if (bus.por_done && por_rise == 0) por_rise = k;
      if (!bus.core_rst && rst_fall == 0) rst_fall = k;
      if (bus.core_ce) ce_seen++;
    end
    check("por_done_rise", 32'(por_rise), 32'd8);
    check("core_rst_fall", 32'(rst_fall), 32'd11);
    check("ce_during_por", 32'(ce_seen),  32'd0);

    // rst_req[1] for 5 cycles: rise at edge 3, synced drop at edge 7, release at edge 10.
    bus.rst_req = 2'b10;
    rst_rise = 0; rst_fall = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk50);
      if (bus.core_rst && rst_rise == 0) rst_rise = k;
      if (!bus.core_rst && rst_rise != 0 && rst_fall == 0) rst_fall = k;
      if (k == 5) bus.rst_req = 2'b00;
    end
    check("req_rst_rise", 32'(rst_rise), 32'd3);
    check("req_rst_fall", 32'(rst_fall), 32'd10);
    check("req_ce_count", 32'(bus.ce_count), 32'd0);

    // Run mode, div_val=3: pulses at edges 7,11,15,19,23.
    bus.run_mode = 1'b1;
    bus.div_val  = 8'd3;
    first = 0; pulses = 0; wide = 0; prev_ce = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk50);
      if (bus.core_ce) begin
        pulses++;
        if (first == 0) first = k;
        if (prev_ce != 0) wide = 1;
      end
      prev_ce = int'(bus.core_ce);
    end
    check("div3_first_pulse", 32'(first),  32'd7);
    check("div3_pulse_count", 32'(pulses), 32'd5);
    check("div3_pulse_width", 32'(wide),   32'd0);
    check("div3_ce_count",    32'(bus.ce_count), 32'd5);

    // div_val=0: div_cnt=2 wraps silently, then a pulse every cycle from edge 27.
    bus.div_val = 8'd0;
    count_pulses(10, pulses);
    check("div0_pulse_count", 32'(pulses), 32'd8);
    check("div0_ce_count",    32'(bus.ce_count), 32'd13);

    // div_val=9, then drop to 4 while div_cnt=7: wrap without tick, gap 10 -> 13 -> 5.
    bus.div_val = 8'd9;
    wait_pulse(20, n);
    wait_pulse(20, n);
    check("div9_gap", 32'(n), 32'd10);
    cycles(6);
    bus.div_val = 8'd4;
    wait_pulse(20, n);
    check("div_shrink_gap", 32'(n), 32'd7);
    wait_pulse(20, n);
    check("div4_gap", 32'(n), 32'd5);

    // Fresh start in step mode.
    bus.run_mode = 1'b0;
    hard_reset();
    check("restart_core_rst", 32'(bus.core_rst), 32'd0);
    check("restart_ce_count", 32'(bus.ce_count), 32'd0);

    // Bounce, then hold low: one pulse at 2 sync + 4 debounce + 1 register edges.
    bus.step_n = 1'b0; @(negedge clk50);
    bus.step_n = 1'b1; @(negedge clk50);
    bus.step_n = 1'b0; @(negedge clk50);
    bus.step_n = 1'b1; @(negedge clk50);
    bus.step_n = 1'b0;
    first = 0; pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk50);
      if (bus.core_ce) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check("step_pulse_at",    32'(first),  32'd7);
    check("step_pulse_count", 32'(pulses), 32'd1);
    check("step_ce_count",    32'(bus.ce_count), 32'd1);
    bus.step_n = 1'b1;
    count_pulses(15, pulses);
    check("release_no_pulse", 32'(pulses), 32'd0);

    // Press during an active reset request is discarded, even after release.
    bus.rst_req = 2'b01;
    cycles(4);
    bus.step_n = 1'b0;
    count_pulses(10, pulses);
    bus.rst_req = 2'b00;
    count_pulses(25, n);
    check("press_in_rst_pulses", 32'(pulses + n), 32'd0);
    check("press_in_rst_ce_count", 32'(bus.ce_count), 32'd0);
    bus.step_n = 1'b1;
    cycles(10);
    bus.step_n = 1'b0;
    count_pulses(12, pulses);
    check("press_after_rst", 32'(pulses), 32'd1);
    bus.step_n = 1'b1;
    cycles(10);

    // Async rst while pulsing every cycle: outputs return without a clock edge.
    bus.run_mode = 1'b1;
    bus.div_val  = 8'd0;
    cycles(10);
    check("run_pulsing", 32'(bus.core_ce), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_core_ce",  32'(bus.core_ce),  32'd0);
    check("async_ce_count", 32'(bus.ce_count), 32'd0);
    check("async_core_rst", 32'(bus.core_rst), 32'd1);
    check("async_por_done", 32'(bus.por_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
